// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Hazard fields, memory handshakes and stall/flush controls that
//            pass between the 5-stage pipeline and its hazard sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic [2:0]       ex_memread;
    logic             mem_branch_taken;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             pc_redirect;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Controller side
    modport master (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
        input  mem_branch_taken, imem_ready, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, pc_redirect,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output mem_timeout, stall_cnt, flush_cnt
    );

    // Pipeline side
    modport slave (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
        output mem_branch_taken, imem_ready, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, pc_redirect,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  mem_timeout, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush sequencer for the 5-stage pipeline: reset hold,
//            load-use / fetch / data-memory stalls, branch flush, timeout halt.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int RESET_HOLD  = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  wire logic            clk,
    input  wire logic            rstn,
    pipe_hazard_ctrl_if.master   bus
);

    localparam int HC_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [HC_W-1:0] c_hold_last = HC_W'(RESET_HOLD - 1);
    localparam logic [WC_W-1:0] c_timeout   = WC_W'(MEM_TIMEOUT);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]       r_state;
    logic [HC_W-1:0]  r_hold_cnt;
    logic [WC_W-1:0]  r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_active;
    logic             w_load_use;
    logic             w_mem_block;
    logic [WC_W-1:0]  w_wait_nxt;

    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
    logic w_pc_redirect;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush;

    assign w_active   = (r_state == S_RUN) || (r_state == S_WAIT);
    assign w_wait_nxt = r_wait_cnt + WC_W'(1);

    assign w_load_use = (bus.ex_memread != 3'd0) && (bus.ex_rd != 5'd0) &&
                        ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // In MEM_WAIT the access is already outstanding, so only dmem_ready matters.
    assign w_mem_block = ((r_state == S_RUN)  && bus.dmem_req && !bus.dmem_ready) ||
                         ((r_state == S_WAIT) && !bus.dmem_ready);

    always_comb begin
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_memwb_en    = 1'b0;
        w_pc_redirect = 1'b0;
        w_ifid_flush  = 1'b1;
        w_idex_flush  = 1'b1;
        w_exmem_flush = 1'b1;
        w_memwb_flush = 1'b1;
        if (w_active) begin
            w_ifid_flush  = 1'b0;
            w_idex_flush  = 1'b0;
            w_exmem_flush = 1'b0;
            w_memwb_flush = 1'b0;
            if (w_mem_block) begin
                w_memwb_flush = 1'b1;
            end else if (bus.mem_branch_taken) begin
                w_pc_en       = 1'b1;
                w_ifid_en     = 1'b1;
                w_idex_en     = 1'b1;
                w_exmem_en    = 1'b1;
                w_memwb_en    = 1'b1;
                w_pc_redirect = 1'b1;
                w_ifid_flush  = 1'b1;
                w_idex_flush  = 1'b1;
                w_exmem_flush = 1'b1;
            end else if (w_load_use) begin
                w_idex_en     = 1'b1;
                w_exmem_en    = 1'b1;
                w_memwb_en    = 1'b1;
                w_idex_flush  = 1'b1;
            end else if (!bus.imem_ready) begin
                w_ifid_en     = 1'b1;
                w_idex_en     = 1'b1;
                w_exmem_en    = 1'b1;
                w_memwb_en    = 1'b1;
                w_ifid_flush  = 1'b1;
            end else begin
                w_pc_en       = 1'b1;
                w_ifid_en     = 1'b1;
                w_idex_en     = 1'b1;
                w_exmem_en    = 1'b1;
                w_memwb_en    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_state <= S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HC_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_mem_block) begin
                        // The first blocked cycle already counts as one wait cycle.
                        if (MEM_TIMEOUT <= 1) begin
                            r_wait_cnt    <= c_timeout;
                            r_mem_timeout <= 1'b1;
                            r_state       <= S_HALT;
                        end else begin
                            r_wait_cnt <= WC_W'(1);
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_mem_block) begin
                        r_wait_cnt <= w_wait_nxt;
                        if (w_wait_nxt == c_timeout) begin
                            r_mem_timeout <= 1'b1;
                            r_state       <= S_HALT;
                        end
                    end else begin
                        r_wait_cnt <= '0;
                        r_state    <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_active && !w_pc_en) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_pc_redirect) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.memwb_en    = w_memwb_en;
    assign bus.pc_redirect = w_pc_redirect;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.memwb_flush = w_memwb_flush;
    assign bus.mem_timeout = r_mem_timeout;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int RH = 4;
    localparam int MT = 64;
    localparam int CW = 32;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_pass   = 0;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(.RESET_HOLD(RH), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: cycles spent in hold, consecutive blocked cycles, halted flag.
    int          m_hold;
    int          m_wait;
    bit          m_halt;
    bit          m_to;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    logic [9:0]  exp_ctl;
    logic [9:0]  act_ctl;
    bit          frozen;
    bit          blocked;
    bit          lu;

    always @(negedge clk) begin
        if (!rstn) begin
            m_hold = 0; m_wait = 0; m_halt = 0; m_to = 0; m_stall = 0; m_flush = 0;
        end
        frozen  = !rstn || (m_hold < RH) || m_halt;
        blocked = !bus.dmem_ready && (m_wait > 0 || bus.dmem_req);
        lu = (bus.ex_memread != 0) && (bus.ex_rd != 0) &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        // {pc,ifid,idex,exmem,memwb en, redirect, ifid,idex,exmem,memwb flush}
        if (frozen)                    exp_ctl = 10'b00000_0_1111;
        else if (blocked)              exp_ctl = 10'b00000_0_0001;
        else if (bus.mem_branch_taken) exp_ctl = 10'b11111_1_1110;
        else if (lu)                   exp_ctl = 10'b00111_0_0100;
        else if (!bus.imem_ready)      exp_ctl = 10'b01111_0_1000;
        else                           exp_ctl = 10'b11111_0_0000;
        act_ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                   bus.pc_redirect, bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
                   bus.memwb_flush};
        chk("ctl", 64'(act_ctl), 64'(exp_ctl));
        chk("mem_timeout", 64'(bus.mem_timeout), 64'(m_to));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(bus.flush_cnt), 64'(m_flush));
        if (rstn) begin
            if (frozen) begin
                if (!m_halt) m_hold++;
            end else begin
                if (!exp_ctl[9]) m_stall = m_stall + 1;
                if (exp_ctl[4])  m_flush = m_flush + 1;
                if (blocked) begin
                    m_wait++;
                    if (m_wait >= MT) begin m_halt = 1; m_to = 1; end
                end else begin
                    m_wait = 0;
                end
            end
        end
    end

    // One cycle: drive after the edge, return at the following falling edge.
    task automatic apply(input bit req, input bit rdy, input bit br, input bit imem,
                         input logic [2:0] mrd, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2);
        @(posedge clk); #1;
        bus.dmem_req = req; bus.dmem_ready = rdy; bus.mem_branch_taken = br;
        bus.imem_ready = imem; bus.ex_memread = mrd; bus.ex_rd = rd;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
        @(negedge clk);
    endtask

    task automatic idle();
        apply(0, 1, 0, 1, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        bus.dmem_req = 0; bus.dmem_ready = 1; bus.mem_branch_taken = 0; bus.imem_ready = 1;
        bus.ex_memread = 0; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
        @(negedge clk);
        chk("rst_pc_en", 64'(bus.pc_en), 64'd0);
        chk("rst_ifid_flush", 64'(bus.ifid_flush), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_pc_en", 64'(bus.pc_en), 64'd0);
            chk("hold_memwb_flush", 64'(bus.memwb_flush), 64'd1);
        end
        idle();
        chk("run_pc_en", 64'(bus.pc_en), 64'd1);
        chk("run_ifid_flush", 64'(bus.ifid_flush), 64'd0);
        chk("run_stall0", 64'(bus.stall_cnt), 64'd0);

        apply(0, 1, 0, 1, 3'b001, 5'd5, 5'd0, 5'd5, 0, 1);
        chk("lu_pc_en", 64'(bus.pc_en), 64'd0);
        chk("lu_ifid_en", 64'(bus.ifid_en), 64'd0);
        chk("lu_idex_flush", 64'(bus.idex_flush), 64'd1);
        chk("lu_exmem_en", 64'(bus.exmem_en), 64'd1);
        idle();
        chk("lu_one_bubble", 64'(bus.pc_en), 64'd1);
        chk("lu_stall1", 64'(bus.stall_cnt), 64'd1);
        apply(0, 1, 0, 1, 3'b001, 5'd0, 5'd0, 5'd0, 0, 1);
        chk("lu_rd0", 64'(bus.pc_en), 64'd1);
        apply(0, 1, 0, 1, 3'b010, 5'd7, 5'd7, 5'd0, 0, 1);
        chk("lu_rs1_unused", 64'(bus.pc_en), 64'd1);
        apply(0, 1, 0, 1, 3'b100, 5'd7, 5'd7, 5'd0, 1, 0);
        chk("lu_rs1", 64'(bus.pc_en), 64'd0);
        apply(0, 1, 0, 1, 3'b000, 5'd7, 5'd7, 5'd7, 1, 1);
        chk("lu_noload", 64'(bus.pc_en), 64'd1);

        apply(0, 1, 1, 1, 3'b001, 5'd5, 5'd5, 5'd0, 1, 0);
        chk("br_redirect", 64'(bus.pc_redirect), 64'd1);
        chk("br_pc_en", 64'(bus.pc_en), 64'd1);
        chk("br_flushes", 64'({bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush}), 64'b1110);
        idle();
        chk("br_stall", 64'(bus.stall_cnt), 64'd2);
        chk("br_flush", 64'(bus.flush_cnt), 64'd1);

        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 1, 1, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
            chk("mw_pc_en", 64'(bus.pc_en), 64'd0);
            chk("mw_memwb_flush", 64'(bus.memwb_flush), 64'd1);
            chk("mw_redirect", 64'(bus.pc_redirect), 64'd0);
        end
        apply(1, 1, 1, 1, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("mw_done_redirect", 64'(bus.pc_redirect), 64'd1);
        idle();
        chk("mw_stall", 64'(bus.stall_cnt), 64'd5);
        chk("mw_flush", 64'(bus.flush_cnt), 64'd2);

        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
            chk("im_pc_en", 64'(bus.pc_en), 64'd0);
            chk("im_ifid_flush", 64'(bus.ifid_flush), 64'd1);
            chk("im_idex_en", 64'(bus.idex_en), 64'd1);
        end
        apply(0, 1, 0, 0, 3'b001, 5'd3, 5'd3, 5'd0, 1, 0);
        chk("im_lu_prio", 64'(bus.ifid_en), 64'd0);
        idle();
        chk("im_stall", 64'(bus.stall_cnt), 64'd8);

        apply(1, 0, 0, 1, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        apply(1, 0, 0, 1, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        @(posedge clk); #1;
        rstn = 1'b0;
        bus.dmem_req = 0; bus.dmem_ready = 1;
        @(negedge clk);
        chk("midrst_stall", 64'(bus.stall_cnt), 64'd0);
        chk("midrst_flush", 64'(bus.flush_cnt), 64'd0);
        chk("midrst_pc_en", 64'(bus.pc_en), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < MT; i++) begin
            apply(1, 0, 0, 1, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
            if (i == MT - 1) chk("to_not_yet", 64'(bus.mem_timeout), 64'd0);
        end
        apply(1, 0, 0, 1, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("to_set", 64'(bus.mem_timeout), 64'd1);
        chk("to_pc_en", 64'(bus.pc_en), 64'd0);
        chk("to_stall", 64'(bus.stall_cnt), 64'd64);
        apply(0, 1, 1, 1, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("halt_redirect", 64'(bus.pc_redirect), 64'd0);
        chk("halt_ifid_flush", 64'(bus.ifid_flush), 64'd1);
        chk("halt_stall", 64'(bus.stall_cnt), 64'd64);
        chk("halt_flush", 64'(bus.flush_cnt), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("to_cleared", 64'(bus.mem_timeout), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (6) idle();
        chk("final_pc_en", 64'(bus.pc_en), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Takes hazard-relevant fields from the ID, EX and MEM stage registers and the instruction/data memory handshakes. Drives the enable and flush controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Holds a reset-hold/run/memory-wait/halt FSM, a data-memory timeout counter and two performance counters.

Parameters:
- RESET_HOLD, 4, cycles after reset release during which PC and all pipeline registers stay frozen and flushed.
- MEM_TIMEOUT, 64, max consecutive cycles waiting on dmem_ready before halting.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous active-low
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of instruction in EX
- ex_memread  in  3  ID/EX-latched MemRead code (nonzero = load)
- mem_branch_taken  in  1  branch/jump in MEM resolved taken
- imem_ready  in  1  instruction fetch data valid this cycle
- dmem_req  in  1  MEM-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register update enables
- pc_redirect  out  1  select branch target into PC
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble (control fields zero) on this edge
- mem_timeout  out  1  sticky, set on data-memory timeout
- stall_cnt  out  CNT_W  cycles with pc_en=0 while in RUN or MEM_WAIT
- flush_cnt  out  CNT_W  cycles with pc_redirect=1

Behaviour:
- Timing:
  - Control outputs are combinational from the registered state plus current inputs, so they act on the same edge.
  - State, counters and mem_timeout are registered.
- Reset (rstn low):
  - state=HOLD, hold counter=0, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - Outputs during reset: all enables 0, all flushes 1, pc_redirect 0.
- HOLD:
  - Outputs are as in reset.
  - Hold counter increments each cycle; after RESET_HOLD cycles in HOLD, go to RUN.
  - Counters do not count in HOLD.
- RUN, priority order (first match wins):
  1. dmem_req && !dmem_ready:
     - All enables 0; memwb_flush=1; other flushes 0.
     - Go to MEM_WAIT with wait counter=1.
  2. mem_branch_taken:
     - All enables 1, pc_redirect=1, ifid_flush=idex_flush=exmem_flush=1.
     - A simultaneous load-use or imem stall is ignored, because the stalled instructions are squashed.
  3. Load-use, i.e. ex_memread!=0 && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)):
     - pc_en=ifid_en=0, idex_flush=1, exmem_en=memwb_en=1.
     - Exactly one bubble per occurrence, because the load leaves EX on the same edge.
  4. !imem_ready:
     - pc_en=0, ifid_en=1, ifid_flush=1, downstream enables 1.
  5. Otherwise: all enables 1, all flushes 0.
- MEM_WAIT:
  - While !dmem_ready:
    - Outputs as in RUN case 1; wait counter increments.
    - When the wait counter reaches MEM_TIMEOUT: set mem_timeout and go to HALT.
  - On dmem_ready: go to RUN; wait counter=0. Outputs that cycle are evaluated as RUN cases 2–5, so a branch held in MEM redirects on the completing cycle.
- HALT:
  - Outputs as in HOLD. Terminal; exits only on reset.
  - mem_timeout stays 1; counters freeze.
- Counters:
  - Unsigned, wrap modulo 2^CNT_W.
  - stall_cnt increments on every RUN/MEM_WAIT cycle with pc_en=0.
  - flush_cnt increments on every cycle with pc_redirect=1.
- Reset asserted mid-stall or mid-wait returns immediately to the reset values above; no partial state survives.

Test Plan:
- Reset release with RESET_HOLD=4, imem_ready=1, no hazards → pc_en=0 and all flushes=1 for 4 cycles after rstn rises, then pc_en=1 and flushes=0 from cycle 5; stall_cnt stays 0.
- Load-use: ex_memread=3'b001, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → pc_en=ifid_en=0, idex_flush=1 for exactly 1 cycle; stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Load-use and mem_branch_taken=1 in the same cycle → pc_redirect=1, ifid/idex/exmem_flush=1, pc_en=1; stall_cnt unchanged; flush_cnt=1.
- dmem_req=1, dmem_ready low for 3 cycles then high, mem_branch_taken=1 throughout → all enables 0 and memwb_flush=1 for 3 cycles; redirect and flushes on the 4th cycle; stall_cnt=3, flush_cnt=1.
- dmem_ready held low with MEM_TIMEOUT=64 → mem_timeout rises after 64 wait cycles; state HALT; all enables stay 0 until rstn pulses low, after which mem_timeout=0.
- imem_ready=0 for 2 cycles in RUN → pc_en=0, ifid_flush=1 for 2 cycles, downstream enables 1; stall_cnt=2.
